// File: rtl/calc1_port_sequencer.sv
// ---------------------------------------------------------------------------
// calc1_port_sequencer
//
// Shares one calc1 command port between NUM_REQ clients. A round-robin
// arbiter picks one pending client, latches its whole transaction, plays it
// onto the calc1 two-cycle input protocol (cmd+op1, then op2), waits for the
// calc1 response (or a timeout) and returns the result to that client.
//
// Ports
//   c_clk          clock, rising edge
//   reset          asynchronous active-low reset
//   req_valid      [NUM_REQ]     client i has a pending transaction
//   req_cmd        [4*NUM_REQ]   client i command, slice [4i+:4]
//   req_op1/op2    [32*NUM_REQ]  client i operands, slice [32i+:32]
//   req_ready      [NUM_REQ]     one-cycle accept pulse to the granted client
//   rsp_valid      [NUM_REQ]     one-cycle result strobe to the granted client
//   rsp_resp/data  result code (3 = timeout) and data, zero outside RESP
//   port_cmd/data  drive calc1 req_cmd_in / req_data_in
//   port_resp/out_data  calc1 out_resp / out_data
//   busy           high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module calc1_port_sequencer #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                    c_clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [4*NUM_REQ-1:0]    req_cmd,
  input  logic [32*NUM_REQ-1:0]   req_op1,
  input  logic [32*NUM_REQ-1:0]   req_op2,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [1:0]              rsp_resp,
  output logic [31:0]             rsp_data,
  output logic [3:0]              port_cmd,
  output logic [31:0]             port_data,
  input  logic [1:0]              port_resp,
  input  logic [31:0]             port_out_data,
  output logic                    busy
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_OP1,
    S_OP2,
    S_WAIT,
    S_RESP
  } state_e;

  state_e state_q, state_d;

  logic [IW-1:0]      last_grant_q, last_grant_d;
  logic [IW-1:0]      grant_q, grant_d;
  logic [3:0]         cmd_q, cmd_d;
  logic [31:0]        op1_q, op1_d;
  logic [31:0]        op2_q, op2_d;
  logic [1:0]         resp_q, resp_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NUM_REQ-1:0] ready_q, ready_d;

  // Arbiter / payload selection
  logic               pick_found;
  logic [IW-1:0]      pick_idx;
  logic [IW-1:0]      cand;
  logic [3:0]         sel_cmd;
  logic [31:0]        sel_op1;
  logic [31:0]        sel_op2;

  logic               wait_hit;
  logic               wait_expired;

  // Round-robin: scan upward from the requester after last_grant, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((32'(last_grant_q) + k) % NUM_REQ);
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_cmd = '0;
    sel_op1 = '0;
    sel_op2 = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IW'(i)) begin
        sel_cmd = req_cmd[4*i +: 4];
        sel_op1 = req_op1[32*i +: 32];
        sel_op2 = req_op2[32*i +: 32];
      end
    end
  end

  assign wait_hit     = (port_resp != 2'd0);
  assign wait_expired = (cnt_q == CW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          state_d = (sel_cmd != 4'd0) ? S_OP1 : S_RESP;
        end
      end
      S_OP1:  state_d = S_OP2;
      S_OP2:  state_d = S_WAIT;
      S_WAIT: begin
        if (wait_hit || wait_expired) begin
          state_d = S_RESP;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    cmd_d        = cmd_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    resp_d       = resp_q;
    rdata_d      = rdata_q;
    cnt_d        = cnt_q;
    ready_d      = '0;
    unique case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          cmd_d   = sel_cmd;
          op1_d   = sel_op1;
          op2_d   = sel_op2;
          ready_d = NUM_REQ'(1) << pick_idx;
          // A null command is answered locally without touching the port.
          if (sel_cmd == 4'd0) begin
            resp_d  = 2'd2;
            rdata_d = '0;
          end
        end
      end
      S_OP2: begin
        cnt_d = '0;
      end
      S_WAIT: begin
        // A response arriving on the timeout edge takes priority.
        if (wait_hit) begin
          resp_d  = port_resp;
          rdata_d = port_out_data;
        end else if (wait_expired) begin
          resp_d  = 2'd3;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP: begin
        last_grant_d = grant_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      last_grant_q <= IW'(NUM_REQ - 1);
      grant_q      <= '0;
      cmd_q        <= '0;
      op1_q        <= '0;
      op2_q        <= '0;
      resp_q       <= '0;
      rdata_q      <= '0;
      cnt_q        <= '0;
      ready_q      <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      cmd_q        <= cmd_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      resp_q       <= resp_d;
      rdata_q      <= rdata_d;
      cnt_q        <= cnt_d;
      ready_q      <= ready_d;
    end
  end

  // Output decode: everything depends only on state and latched registers,
  // so an asynchronous reset drops the port back to cmd=0/data=0 at once.
  always_comb begin
    port_cmd  = '0;
    port_data = '0;
    rsp_valid = '0;
    rsp_resp  = '0;
    rsp_data  = '0;
    req_ready = ready_q;
    busy      = (state_q != S_IDLE);
    unique case (state_q)
      S_OP1: begin
        port_cmd  = cmd_q;
        port_data = op1_q;
      end
      S_OP2: begin
        port_data = op2_q;
      end
      S_RESP: begin
        rsp_valid = NUM_REQ'(1) << grant_q;
        rsp_resp  = resp_q;
        rsp_data  = rdata_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_calc1_port_sequencer.sv
// ---------------------------------------------------------------------------
// tb_calc1_port_sequencer
//
// Scoreboard bench: client transactions are queued per client; when one is
// driven onto req_* its expected result is pushed to that client's queue.
// A monitor pops and compares on every rsp_valid, checks each grant against
// a round-robin reference, and a small calc1 responder checks port traffic.
// ---------------------------------------------------------------------------
module tb_calc1_port_sequencer;

  localparam int unsigned NR = 4;
  localparam int unsigned TO = 15;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     req_valid;
  logic [4*NR-1:0]   req_cmd;
  logic [32*NR-1:0]  req_op1;
  logic [32*NR-1:0]  req_op2;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     rsp_valid;
  logic [1:0]        rsp_resp;
  logic [31:0]       rsp_data;
  logic [3:0]        port_cmd;
  logic [31:0]       port_data;
  logic [1:0]        port_resp;
  logic [31:0]       port_out_data;
  logic              busy;

  calc1_port_sequencer #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
    .c_clk(clk), .reset(rst_n),
    .req_valid(req_valid), .req_cmd(req_cmd), .req_op1(req_op1), .req_op2(req_op2),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_resp(rsp_resp), .rsp_data(rsp_data),
    .port_cmd(port_cmd), .port_data(port_data), .port_resp(port_resp),
    .port_out_data(port_out_data), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] op1;
    logic [31:0] op2;
    int unsigned dly;     // calc1 latency in WAIT cycles (> TO means never)
    logic [1:0]  eresp;
    logic [31:0] edata;
  } txn_t;

  txn_t pend_q [NR][$];
  txn_t exp_q  [NR][$];
  txn_t cur_rec [NR];
  txn_t gr_rec;
  int   grant_log [$];
  int   last_ref = NR - 1;

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Reference calc1 behaviour used by the responder.
  function automatic logic [33:0] calc_ref(input logic [3:0] c, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    case (c)
      4'd1:    return s[32] ? {2'd2, 32'd0} : {2'd1, s[31:0]};
      4'd2:    return (a < b) ? {2'd2, 32'd0} : {2'd1, a - b};
      default: return {2'd2, 32'd0};
    endcase
  endfunction

  function automatic txn_t mk(input logic [3:0] c, input logic [31:0] a,
                              input logic [31:0] b, input int unsigned d);
    txn_t t;
    logic [33:0] r;
    t.cmd = c; t.op1 = a; t.op2 = b; t.dly = d;
    r = calc_ref(c, a, b);
    if (c == 4'd0)   begin t.eresp = 2'd2; t.edata = 32'd0; end
    else if (d > TO) begin t.eresp = 2'd3; t.edata = 32'd0; end
    else             begin t.eresp = r[33:32]; t.edata = r[31:0]; end
    return t;
  endfunction

  function automatic int rr_pick(input int last, input logic [NR-1:0] v);
    for (int k = 1; k <= NR; k++) begin
      if (v[(last + k) % NR]) return (last + k) % NR;
    end
    return -1;
  endfunction

  function automatic bit quiet();
    for (int i = 0; i < NR; i++) begin
      if (pend_q[i].size() != 0 || exp_q[i].size() != 0) return 1'b0;
    end
    return (req_valid == '0) && !busy;
  endfunction

  // Client driver: holds each transaction until its ready pulse, then either
  // issues the next queued one immediately or drops valid and scrambles payload.
  initial begin
    txn_t t;
    req_valid = '0; req_cmd = '0; req_op1 = '0; req_op2 = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        if (!rst_n) begin
          req_valid[i] = 1'b0;
          continue;
        end
        if (req_valid[i] && req_ready[i]) begin
          req_valid[i] = 1'b0;
          req_cmd[4*i +: 4]  = 4'($urandom);
          req_op1[32*i +: 32] = $urandom;
          req_op2[32*i +: 32] = $urandom;
        end
        if (!req_valid[i] && pend_q[i].size() != 0) begin
          t = pend_q[i].pop_front();
          req_cmd[4*i +: 4]   = t.cmd;
          req_op1[32*i +: 32] = t.op1;
          req_op2[32*i +: 32] = t.op2;
          req_valid[i] = 1'b1;
          cur_rec[i] = t;
          exp_q[i].push_back(t);
        end
      end
    end
  end

  // Monitor: grants and responses, sampled 1 time unit after the clock edge.
  initial begin
    bit was_rsp = 1'b0;
    int ge;
    int g;
    txn_t t;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin was_rsp = 1'b0; continue; end
      if (was_rsp) chk("busy_after_resp", 32'(busy), 32'd0);
      was_rsp = (rsp_valid != '0);
      if (req_ready != '0) begin
        ge = rr_pick(last_ref, req_valid);
        chk("grant_rr", 32'(req_ready), (ge < 0) ? 32'd0 : (32'd1 << ge));
        g = 0;
        for (int k = NR - 1; k >= 0; k--) if (req_ready[k]) g = k;
        gr_rec = cur_rec[g];
        last_ref = g;
        grant_log.push_back(g);
      end
      if (rsp_valid != '0) begin
        chk("rsp_onehot", 32'($onehot(rsp_valid)), 32'd1);
        g = 0;
        for (int k = NR - 1; k >= 0; k--) if (rsp_valid[k]) g = k;
        if (exp_q[g].size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          t = exp_q[g].pop_front();
          chk("rsp_resp", 32'(rsp_resp), 32'(t.eresp));
          chk("rsp_data", rsp_data, t.edata);
        end
      end else begin
        chk("rsp_idle_zero", {rsp_resp, rsp_data[29:0]} | 32'(rsp_data[31:30]), 32'd0);
      end
    end
  end

  // calc1 responder: watches the port mid-cycle and answers after gr_rec.dly
  // WAIT cycles. Noise is driven on port_resp while the sequencer is idle.
  initial begin
    int unsigned ph = 0;
    int unsigned cnt = 0;
    logic [3:0]  c;
    logic [31:0] a, b;
    txn_t r;
    port_resp = '0; port_out_data = '0;
    forever begin
      @(negedge clk);
      port_resp = '0;
      port_out_data = $urandom;
      if (!rst_n) begin ph = 0; continue; end
      case (ph)
        0: begin
          if (port_cmd != 4'd0) begin
            r = gr_rec;
            chk("port_cmd", 32'(port_cmd), 32'(r.cmd));
            chk("port_op1", port_data, r.op1);
            c = port_cmd; a = port_data; ph = 1;
          end else begin
            chk("port_idle_data", port_data, 32'd0);
            if (!busy) port_resp = 2'($urandom_range(0, 3));
          end
        end
        1: begin
          chk("port_op2_cmd", 32'(port_cmd), 32'd0);
          chk("port_op2", port_data, r.op2);
          b = port_data; cnt = 0; ph = 2;
        end
        default: begin
          chk("port_wait", {port_cmd, port_data[27:0]} | 32'(port_data[31:28]), 32'd0);
          cnt++;
          if (cnt == r.dly) begin
            {port_resp, port_out_data} = calc_ref(c, a, b);
            ph = 0;
          end else if (cnt >= TO) begin
            ph = 0;
          end
        end
      endcase
    end
  end

  task automatic chk_zero(input string nm);
    chk({nm, "_ready"}, 32'(req_ready), 32'd0);
    chk({nm, "_rspv"},  32'(rsp_valid), 32'd0);
    chk({nm, "_resp"},  32'(rsp_resp), 32'd0);
    chk({nm, "_rdata"}, rsp_data, 32'd0);
    chk({nm, "_pcmd"},  32'(port_cmd), 32'd0);
    chk({nm, "_pdata"}, port_data, 32'd0);
    chk({nm, "_busy"},  32'(busy), 32'd0);
  endtask

  task automatic wait_quiet(input int unsigned budget);
    int unsigned n = 0;
    while (n < budget && !quiet()) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(quiet()), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_order(input string nm, input int a, input int b);
    chk({nm, "_len"}, 32'(grant_log.size()), 32'd2);
    if (grant_log.size() >= 2) begin
      chk({nm, "_first"},  32'(grant_log[0]), 32'(a));
      chk({nm, "_second"}, 32'(grant_log[1]), 32'(b));
    end
    grant_log.delete();
  endtask

  initial begin
    int unsigned n;
    int i;
    int unsigned r;
    logic [3:0] c;
    logic [31:0] a, b;

    repeat (3) @(negedge clk);
    chk_zero("reset");
    #2 rst_n = 1'b1;

    // All four clients at once from reset: 0,1,2,3
    for (int k = 0; k < NR; k++) pend_q[k].push_back(mk(4'd1, 32'(k), 32'(k + 10), 2));
    wait_quiet(500);
    chk("order4_len", 32'(grant_log.size()), 32'd4);
    for (int k = 0; k < NR; k++)
      if (k < grant_log.size()) chk("order4", 32'(grant_log[k]), 32'(k));
    grant_log.delete();

    // After last grant 3, client 0 beats client 2
    pend_q[2].push_back(mk(4'd2, 32'd50, 32'd8, 1));
    pend_q[0].push_back(mk(4'd1, 32'd7, 32'd9, 4));
    wait_quiet(300);
    chk_order("order20", 0, 2);

    // Directed cases
    pend_q[0].push_back(mk(4'd1, 32'd1, 32'd2, 3));
    wait_quiet(100);
    pend_q[1].push_back(mk(4'd0, 32'hDEAD_BEEF, 32'h1234_5678, 1));
    wait_quiet(100);
    pend_q[3].push_back(mk(4'd1, 32'd5, 32'd6, 99));
    wait_quiet(100);
    pend_q[0].push_back(mk(4'd1, 32'hFFFF_FFFF, 32'd1, 2));
    wait_quiet(100);
    pend_q[2].push_back(mk(4'd1, 32'd100, 32'd23, TO));
    wait_quiet(100);
    pend_q[1].push_back(mk(4'd2, 32'd9, 32'd4, TO + 1));
    wait_quiet(100);
    pend_q[3].push_back(mk(4'd9, 32'd1, 32'd1, 1));
    wait_quiet(100);
    grant_log.delete();

    // Reset during WAIT of a client-2 transaction
    pend_q[2].push_back(mk(4'd1, 32'd3, 32'd4, 99));
    n = 0;
    while (!req_ready[2] && n < 50) begin @(negedge clk); n++; end
    chk("rst_grant", 32'(req_ready[2]), 32'd1);
    repeat (2) @(posedge clk);
    #2;
    chk("rst_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_zero("midreset");
    repeat (2) @(negedge clk);
    for (int k = 0; k < NR; k++) begin exp_q[k].delete(); pend_q[k].delete(); end
    last_ref = NR - 1;
    grant_log.delete();
    pend_q[2].push_back(mk(4'd2, 32'd40, 32'd2, 2));
    pend_q[0].push_back(mk(4'd1, 32'd11, 32'd22, 3));
    #3 rst_n = 1'b1;
    wait_quiet(300);
    chk_order("order_after_reset", 0, 2);

    // Randomised traffic
    for (int t = 0; t < 200; t++) begin
      i = int'($urandom_range(0, NR - 1));
      r = $urandom_range(0, 9);
      c = (r == 0) ? 4'd0 : (r <= 4) ? 4'd1 : (r <= 7) ? 4'd2 : 4'($urandom_range(3, 15));
      a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3)) : $urandom;
      b = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      pend_q[i].push_back(mk(c, a, b,
        ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 1, TO + 2) : $urandom_range(1, 5)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_quiet(20000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
